// File: rtl/ascon_pkg.sv
// Shared Ascon types: state words, the 5-word permutation state and the round sequencer states.
package ascon_pkg;

   localparam int ASCON_MAX_ROUNDS = 12;

   typedef logic [63:0] ascon_word_t;
   typedef ascon_word_t [4:0] ascon_state_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } asconp_ctrl_state_e;

endpackage

// File: rtl/asconp_round_ctrl.sv
// Round sequencer for a single-round Ascon-p datapath: owns the state register and round index.
// Optional completed-permutation counter (perm_count_o) is built when ASCONP_CTRL_PERF_CNT_EN is defined.
module asconp_round_ctrl
   import ascon_pkg::*;
#(
   parameter int MAX_ROUNDS = ASCON_MAX_ROUNDS
`ifdef ASCONP_CTRL_PERF_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [3:0]  rounds_i,
   input  logic [63:0] x0_i,
   input  logic [63:0] x1_i,
   input  logic [63:0] x2_i,
   input  logic [63:0] x3_i,
   input  logic [63:0] x4_i,
   input  logic        flush_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [63:0] x0_o,
   output logic [63:0] x1_o,
   output logic [63:0] x2_o,
   output logic [63:0] x3_o,
   output logic [63:0] x4_o,
   output logic [3:0]  perm_round_o,
   output logic [63:0] perm_x0_o,
   output logic [63:0] perm_x1_o,
   output logic [63:0] perm_x2_o,
   output logic [63:0] perm_x3_o,
   output logic [63:0] perm_x4_o,
   input  logic [63:0] perm_x0_i,
   input  logic [63:0] perm_x1_i,
   input  logic [63:0] perm_x2_i,
   input  logic [63:0] perm_x3_i,
   input  logic [63:0] perm_x4_i,
   output logic        busy_o
`ifdef ASCONP_CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perm_count_o
`endif
);

   localparam logic [3:0] MAX_R  = 4'(MAX_ROUNDS);
   localparam logic [3:0] LAST_R = 4'(MAX_ROUNDS - 1);

   asconp_ctrl_state_e st_q, st_d;
   ascon_state_t       state_q, state_d;
   logic [3:0]         round_q, round_d;
   logic [3:0]         r_eff;
   ascon_state_t       in_state, perm_state;

   assign in_state   = {x4_i, x3_i, x2_i, x1_i, x0_i};
   assign perm_state = {perm_x4_i, perm_x3_i, perm_x2_i, perm_x1_i, perm_x0_i};

   // Oversized requests run the full permutation.
   assign r_eff = (rounds_i > MAX_R) ? MAX_R : rounds_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         st_q    <= IDLE;
         state_q <= '0;
         round_q <= '0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         round_q <= round_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      state_d = state_q;
      round_d = round_q;
      if (flush_i) begin
         st_d    = IDLE;
         round_d = '0;
      end else begin
         case (st_q)
            IDLE: begin
               if (in_valid_i) begin
                  state_d = in_state;
                  if (r_eff == 4'd0) begin
                     st_d = DONE;
                  end else begin
                     round_d = MAX_R - r_eff;
                     st_d    = RUN;
                  end
               end
            end
            RUN: begin
               state_d = perm_state;
               // Park the index at 0 after the last round so it never exceeds MAX_ROUNDS-1.
               if (round_q == LAST_R) begin
                  round_d = '0;
                  st_d    = DONE;
               end else begin
                  round_d = round_q + 4'd1;
               end
            end
            DONE: begin
               if (out_ready_i) st_d = IDLE;
            end
            default: st_d = IDLE;
         endcase
      end
   end

   assign in_ready_o   = (st_q == IDLE);
   assign busy_o       = (st_q == RUN);
   assign out_valid_o  = (st_q == DONE);
   assign perm_round_o = (st_q == RUN) ? round_q : 4'd0;

   assign x0_o = state_q[0];
   assign x1_o = state_q[1];
   assign x2_o = state_q[2];
   assign x3_o = state_q[3];
   assign x4_o = state_q[4];

   assign perm_x0_o = state_q[0];
   assign perm_x1_o = state_q[1];
   assign perm_x2_o = state_q[2];
   assign perm_x3_o = state_q[3];
   assign perm_x4_o = state_q[4];

`ifdef ASCONP_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] perm_cnt_q;

   // A flushed handshake is not a completed permutation.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         perm_cnt_q <= '0;
      else if ((st_q == DONE) && out_ready_i && !flush_i)
         perm_cnt_q <= perm_cnt_q + 1'b1;
   end

   assign perm_count_o = perm_cnt_q;
`endif

endmodule

// File: tb/tb_asconp_round_ctrl.sv
// Directed bench for asconp_round_ctrl with a switchable identity / Ascon-round stub datapath.
module tb_asconp_round_ctrl;
   import ascon_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   rounds = 4'd0;
   ascon_state_t x_in = '0;
   logic         flush = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   ascon_state_t x_out;
   logic [3:0]   perm_round;
   ascon_state_t perm_out;
   ascon_state_t perm_in;
   logic         busy;
   logic         use_golden = 1'b0;
`ifdef ASCONP_CTRL_PERF_CNT_EN
   logic [31:0]  perm_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   asconp_round_ctrl dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .rounds_i(rounds),
      .x0_i(x_in[0]), .x1_i(x_in[1]), .x2_i(x_in[2]), .x3_i(x_in[3]), .x4_i(x_in[4]),
      .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .x0_o(x_out[0]), .x1_o(x_out[1]), .x2_o(x_out[2]), .x3_o(x_out[3]), .x4_o(x_out[4]),
      .perm_round_o(perm_round),
      .perm_x0_o(perm_out[0]), .perm_x1_o(perm_out[1]), .perm_x2_o(perm_out[2]),
      .perm_x3_o(perm_out[3]), .perm_x4_o(perm_out[4]),
      .perm_x0_i(perm_in[0]), .perm_x1_i(perm_in[1]), .perm_x2_i(perm_in[2]),
      .perm_x3_i(perm_in[3]), .perm_x4_i(perm_in[4]),
      .busy_o(busy)
`ifdef ASCONP_CTRL_PERF_CNT_EN
      , .perm_count_o(perm_count)
`endif
   );

   function automatic ascon_word_t ror(ascon_word_t x, int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   // One Ascon-p round: constant addition, bitsliced S-box, linear diffusion.
   function automatic ascon_state_t asc_round(ascon_state_t s, logic [3:0] r);
      ascon_word_t x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      logic [3:0] hi;
      ascon_state_t o;
      hi = 4'hF - r;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      x2 = x2 ^ {56'd0, hi, r};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      o[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      o[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      o[2] = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      o[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      o[4] = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
      return o;
   endfunction

   always_comb begin
      perm_in = perm_out;
      if (use_golden) perm_in = asc_round(perm_out, perm_round);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request in the current (IDLE) cycle; returns in cycle 1 after the accept.
   task automatic start(input logic [3:0] r, input ascon_state_t s);
      in_valid = 1'b1;
      rounds   = r;
      x_in     = s;
      step();
      in_valid = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || perm_round !== 4'd0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b round=%0d, want 1 0 0 0",
                  in_ready, out_valid, busy, perm_round);
      end
      checks++;
      if (x_out !== '0 || perm_out !== '0) begin
         errors++;
         $display("FAIL reset_state: x_out=%h perm_out=%h, want 0", x_out, perm_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_p12();
      ascon_state_t s;
      s = {64'd5, 64'd4, 64'd3, 64'd2, 64'd1};
      start(4'd12, s);
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (perm_round !== 4'(i) || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL p12_run cyc%0d: round=%0d busy=%b in_ready=%b out_valid=%b, want %0d 1 0 0",
                     i + 1, perm_round, busy, in_ready, out_valid, i);
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b0 || perm_round !== 4'd0 || x_out !== s) begin
         errors++;
         $display("FAIL p12_done: out_valid=%b busy=%b round=%0d x=%h, want 1 0 0 %h",
                  out_valid, busy, perm_round, x_out, s);
      end
      handshake();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL p12_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_p6_golden();
      ascon_state_t s, exp;
      s = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
           64'hdeadbeefcafef00d, 64'h80400c0600000000};
      exp = s;
      for (int i = 6; i < 12; i++) exp = asc_round(exp, 4'(i));
      use_golden = 1'b1;
      start(4'd6, s);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (perm_round !== 4'(6 + i) || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL p6_run cyc%0d: round=%0d busy=%b out_valid=%b, want %0d 1 0",
                     i + 1, perm_round, busy, out_valid, 6 + i);
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b1 || x_out !== exp) begin
         errors++;
         $display("FAIL p6_result: out_valid=%b x=%h, want 1 %h", out_valid, x_out, exp);
      end
      handshake();
      use_golden = 1'b0;
   endtask

   task automatic test_zero_and_clamp();
      ascon_state_t s;
      s = {64'haaaa, 64'hbbbb, 64'hcccc, 64'hdddd, 64'heeee};
      start(4'd0, s);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b0 || perm_round !== 4'd0 || x_out !== s) begin
         errors++;
         $display("FAIL r0_done: out_valid=%b busy=%b round=%0d x=%h, want 1 0 0 %h",
                  out_valid, busy, perm_round, x_out, s);
      end
      handshake();
      start(4'd15, s);
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (perm_round !== 4'(i) || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL r15_run cyc%0d: round=%0d busy=%b out_valid=%b, want %0d 1 0",
                     i + 1, perm_round, busy, out_valid, i);
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b1 || x_out !== s) begin
         errors++;
         $display("FAIL r15_done: out_valid=%b x=%h, want 1 %h", out_valid, x_out, s);
      end
      handshake();
   endtask

   task automatic test_backpressure();
      ascon_state_t s, other;
      s     = {64'h11, 64'h22, 64'h33, 64'h44, 64'h55};
      other = {64'h99, 64'h98, 64'h97, 64'h96, 64'h95};
      start(4'd2, s);
      step();
      step();
      // A request arriving while DONE must be ignored.
      in_valid = 1'b1;
      rounds   = 4'd1;
      x_in     = other;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== s) begin
            errors++;
            $display("FAIL bp_hold cyc%0d: out_valid=%b in_ready=%b x=%h, want 1 0 %h",
                     i, out_valid, in_ready, x_out, s);
         end
         step();
      end
      in_valid  = 1'b0;
      handshake();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || x_out !== s) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b x=%h, want 1 0 0 %h",
                  in_ready, out_valid, busy, x_out, s);
      end
   endtask

   task automatic test_flush();
      ascon_state_t s, s2, exp_hold, exp2;
      s  = {64'h1, 64'h2, 64'h3, 64'h4, 64'h5};
      s2 = {64'h6, 64'h7, 64'h8, 64'h9, 64'ha};
      exp_hold = s;
      for (int i = 0; i < 3; i++) exp_hold = asc_round(exp_hold, 4'(i));
      exp2 = s2;
      for (int i = 0; i < 12; i++) exp2 = asc_round(exp2, 4'(i));
      use_golden = 1'b1;
      start(4'd12, s);
      step();
      step();
      step();
      checks++;
      if (perm_round !== 4'd3 || busy !== 1'b1) begin
         errors++;
         $display("FAIL flush_pre: round=%0d busy=%b, want 3 1", perm_round, busy);
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      rounds   = 4'd12;
      x_in     = s2;
      step();
      flush = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || perm_round !== 4'd0 ||
          x_out !== exp_hold) begin
         errors++;
         $display("FAIL flush_idle: in_ready=%b busy=%b out_valid=%b round=%0d x=%h, want 1 0 0 0 %h",
                  in_ready, busy, out_valid, perm_round, x_out, exp_hold);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (x_out !== s2) begin
         errors++;
         $display("FAIL flush_reload: x=%h, want %h", x_out, s2);
      end
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (perm_round !== 4'(i) || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_rerun cyc%0d: round=%0d busy=%b out_valid=%b, want %0d 1 0",
                     i + 1, perm_round, busy, out_valid, i);
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b1 || x_out !== exp2) begin
         errors++;
         $display("FAIL flush_result: out_valid=%b x=%h, want 1 %h", out_valid, x_out, exp2);
      end
      handshake();
      use_golden = 1'b0;
   endtask

   task automatic test_async_reset();
      start(4'd8, {64'h5a, 64'h5b, 64'h5c, 64'h5d, 64'h5e});
      step();
      step();
      rst_n = 1'b0;
      #2;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || perm_round !== 4'd0 ||
          x_out !== '0) begin
         errors++;
         $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b round=%0d x=%h, want 1 0 0 0 0",
                  in_ready, out_valid, busy, perm_round, x_out);
      end
`ifdef ASCONP_CTRL_PERF_CNT_EN
      checks++;
      if (perm_count !== 32'd0) begin
         errors++;
         $display("FAIL async_reset_cnt: count=%0d, want 0", perm_count);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

`ifdef ASCONP_CTRL_PERF_CNT_EN
   task automatic test_perf_cnt();
      for (int k = 1; k <= 3; k++) begin
         start(4'd8, {64'(k), 64'h1, 64'h2, 64'h3, 64'h4});
         for (int i = 0; i < 8; i++) step();
         handshake();
         checks++;
         if (perm_count !== 32'(k)) begin
            errors++;
            $display("FAIL perf_cnt run%0d: count=%0d, want %0d", k, perm_count, k);
         end
      end
      start(4'd8, {64'h7, 64'h1, 64'h2, 64'h3, 64'h4});
      for (int i = 0; i < 8; i++) step();
      // Flush wins over a simultaneous output handshake.
      flush     = 1'b1;
      out_ready = 1'b1;
      step();
      flush     = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (perm_count !== 32'd3 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL perf_cnt_flush: count=%0d in_ready=%b, want 3 1", perm_count, in_ready);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_p12();
      test_p6_golden();
      test_zero_and_clamp();
      test_backpressure();
      test_flush();
      test_async_reset();
`ifdef ASCONP_CTRL_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
